// File: rtl/seq_table_scheduler.sv
// Serializes counter updates, expected-seq lookups and outgoing seq allocation onto the
// per-host sequence RAM and the BCD converter. Define SEQ_RR_ARB_EN for round-robin arbitration.
module seq_table_scheduler #(
  parameter int HOST_ADDR_WIDTH = 4,
  parameter int SEQ_WIDTH       = 32,
  parameter int CONV_TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [HOST_ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [SEQ_WIDTH-1:0]       upd_value_i,
  input  logic                       exp_req_valid_i,
  output logic                       exp_req_ready_o,
  input  logic [HOST_ADDR_WIDTH-1:0] exp_addr_i,
  output logic                       exp_valid_o,
  output logic [SEQ_WIDTH-1:0]       exp_seq_o,
  input  logic                       out_valid_i,
  output logic                       out_ready_o,
  input  logic [HOST_ADDR_WIDTH-1:0] out_addr_i,
  output logic                       out_seq_valid_o,
  output logic [SEQ_WIDTH-1:0]       out_seq_bin_o,
  output logic [HOST_ADDR_WIDTH-1:0] out_host_o,
  output logic [HOST_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                       mem_we_o,
  output logic [SEQ_WIDTH-1:0]       mem_wdata_o,
  input  logic [SEQ_WIDTH-1:0]       mem_rdata_i,
  output logic                       conv_start_o,
  output logic [SEQ_WIDTH-1:0]       conv_bin_o,
  input  logic                       conv_done_i,
  output logic                       busy_o,
  output logic                       err_timeout_o
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_ACCESS    = 3'd2;
  localparam logic [2:0] S_RDATA     = 3'd3;
  localparam logic [2:0] S_CONV      = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  localparam logic [1:0] OP_UPD = 2'd0;
  localparam logic [1:0] OP_EXP = 2'd1;
  localparam logic [1:0] OP_OUT = 2'd2;

  localparam int               TMR_W    = $clog2(CONV_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CONV_TIMEOUT - 1);

  logic [2:0]                 state;
  logic [1:0]                 op;
  logic [HOST_ADDR_WIDTH-1:0] init_addr;
  logic [HOST_ADDR_WIDTH-1:0] addr_q;
  logic [SEQ_WIDTH-1:0]       value_q;
  logic [TMR_W-1:0]           tmr;
  logic [2:0]                 req;
  logic [2:0]                 gnt;
  logic [1:0]                 gnt_op;
  logic [HOST_ADDR_WIDTH-1:0] gnt_addr;
  logic                       idle;

  // Counter advance; the all-ones value wraps to zero.
  function automatic logic [SEQ_WIDTH-1:0] seq_inc(input logic [SEQ_WIDTH-1:0] v);
    return v + SEQ_WIDTH'(1);
  endfunction

  assign req  = {out_valid_i, exp_req_valid_i, upd_valid_i};
  assign idle = (state == S_IDLE) && !rst;

`ifdef SEQ_RR_ARB_EN
  logic [1:0] last_gnt;

  // The requester after the last winner gets first look.
  function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      OP_UPD:  g = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      OP_EXP:  g = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  assign gnt = pick_rr(req, last_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= OP_OUT;
    end else if (idle && (|gnt)) begin
      last_gnt <= gnt_op;
    end
  end
`else
  function automatic logic [2:0] pick_fixed(input logic [2:0] r);
    logic [2:0] g;
    g = 3'b000;
    if (r[0])      g = 3'b001;
    else if (r[1]) g = 3'b010;
    else if (r[2]) g = 3'b100;
    return g;
  endfunction

  assign gnt = pick_fixed(req);
`endif

  always_comb begin
    gnt_op   = OP_OUT;
    gnt_addr = out_addr_i;
    if (gnt[0]) begin
      gnt_op   = OP_UPD;
      gnt_addr = upd_addr_i;
    end else if (gnt[1]) begin
      gnt_op   = OP_EXP;
      gnt_addr = exp_addr_i;
    end
  end

  assign upd_ready_o     = idle && gnt[0];
  assign exp_req_ready_o = idle && gnt[1];
  assign out_ready_o     = idle && gnt[2];
  assign busy_o          = rst || (state != S_IDLE);
  assign conv_start_o    = !rst && (state == S_CONV);

  // RAM port: INIT clears the table, ACCESS reads or writes, RDATA writes back the increment.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (!rst) begin
      case (state)
        S_INIT: begin
          mem_addr_o = init_addr;
          mem_we_o   = 1'b1;
        end
        S_ACCESS: begin
          mem_addr_o = addr_q;
          if (op == OP_UPD) begin
            mem_we_o    = 1'b1;
            mem_wdata_o = value_q;
          end
        end
        S_RDATA: begin
          mem_addr_o = addr_q;
          if (op == OP_OUT) begin
            mem_we_o    = 1'b1;
            mem_wdata_o = seq_inc(mem_rdata_i);
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture at the handshake
  always_ff @(posedge clk) begin
    if (idle && (|gnt)) begin
      addr_q  <= gnt_addr;
      value_q <= upd_value_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_INIT;
      op              <= OP_UPD;
      init_addr       <= '0;
      tmr             <= '0;
      exp_valid_o     <= 1'b0;
      exp_seq_o       <= '0;
      out_seq_valid_o <= 1'b0;
      out_seq_bin_o   <= '0;
      out_host_o      <= '0;
      conv_bin_o      <= '0;
      err_timeout_o   <= 1'b0;
    end else begin
      exp_valid_o     <= 1'b0;
      out_seq_valid_o <= 1'b0;
      case (state)
        S_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (init_addr == '1) state <= S_IDLE;
        end
        S_IDLE: begin
          if (|gnt) begin
            op    <= gnt_op;
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state <= (op == OP_UPD) ? S_IDLE : S_RDATA;
        end
        S_RDATA: begin
          if (op == OP_EXP) begin
            exp_seq_o   <= mem_rdata_i;
            exp_valid_o <= 1'b1;
            state       <= S_IDLE;
          end else begin
            conv_bin_o    <= mem_rdata_i;
            out_seq_bin_o <= mem_rdata_i;
            state         <= S_CONV;
          end
        end
        S_CONV: begin
          tmr   <= '0;
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (conv_done_i) begin
            out_seq_valid_o <= 1'b1;
            out_host_o      <= addr_q;
            state           <= S_IDLE;
          end else if (tmr == TMR_LAST) begin
            err_timeout_o <= 1'b1;
            state         <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_table_scheduler.sv
// Randomized bench for seq_table_scheduler: a transaction-level table model and
// arbitration model predict every RAM access, lookup result and allocation.
module tb_seq_table_scheduler;

  localparam int AW        = 4;
  localparam int SW        = 32;
  localparam int TO        = 64;
  localparam int DEPTH     = 1 << AW;
  localparam int CYC_LIMIT = 200;

  logic          clk;
  logic          rst;
  logic          upd_valid_i;
  logic          upd_ready_o;
  logic [AW-1:0] upd_addr_i;
  logic [SW-1:0] upd_value_i;
  logic          exp_req_valid_i;
  logic          exp_req_ready_o;
  logic [AW-1:0] exp_addr_i;
  logic          exp_valid_o;
  logic [SW-1:0] exp_seq_o;
  logic          out_valid_i;
  logic          out_ready_o;
  logic [AW-1:0] out_addr_i;
  logic          out_seq_valid_o;
  logic [SW-1:0] out_seq_bin_o;
  logic [AW-1:0] out_host_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [SW-1:0] mem_wdata_o;
  logic [SW-1:0] mem_rdata_i;
  logic          conv_start_o;
  logic [SW-1:0] conv_bin_o;
  logic          conv_done_i;
  logic          busy_o;
  logic          err_timeout_o;

  seq_table_scheduler #(
    .HOST_ADDR_WIDTH(AW),
    .SEQ_WIDTH(SW),
    .CONV_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_addr_i(upd_addr_i), .upd_value_i(upd_value_i),
    .exp_req_valid_i(exp_req_valid_i), .exp_req_ready_o(exp_req_ready_o),
    .exp_addr_i(exp_addr_i), .exp_valid_o(exp_valid_o), .exp_seq_o(exp_seq_o),
    .out_valid_i(out_valid_i), .out_ready_o(out_ready_o), .out_addr_i(out_addr_i),
    .out_seq_valid_o(out_seq_valid_o), .out_seq_bin_o(out_seq_bin_o), .out_host_o(out_host_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .conv_start_o(conv_start_o), .conv_bin_o(conv_bin_o), .conv_done_i(conv_done_i),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  // Single-port RAM with one-cycle read latency
  logic [SW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  logic [SW-1:0] ref_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rr_last  = 2;
  int last_acc [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_grant(input int pu, input bit pe, input bit po);
    bit [2:0] p;
    p = {po, pe, (pu > 0)};
`ifdef SEQ_RR_ARB_EN
    for (int k = 1; k <= 3; k++) if (p[(rr_last + k) % 3]) return (rr_last + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    upd_valid_i = 1'b0; exp_req_valid_i = 1'b0; out_valid_i = 1'b0; conv_done_i = 1'b0;
    tick(); tick(); #1;
    check("rst_busy", busy_o, 1);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_conv_start", conv_start_o, 0);
    check("rst_exp_valid", exp_valid_o, 0);
    check("rst_exp_seq", exp_seq_o, 0);
    check("rst_out_valid", out_seq_valid_o, 0);
    check("rst_out_bin", out_seq_bin_o, 0);
    check("rst_out_host", out_host_o, 0);
    check("rst_conv_bin", conv_bin_o, 0);
    check("rst_err", err_timeout_o, 0);
    rst = 1'b0;
    upd_valid_i = 1'b1; exp_req_valid_i = 1'b1; out_valid_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("init_we", mem_we_o, 1);
      check("init_addr", mem_addr_o, i);
      check("init_wdata", mem_wdata_o, 0);
      check("init_busy", busy_o, 1);
      check("init_ready", {out_ready_o, exp_req_ready_o, upd_ready_o}, 0);
      if (i == DEPTH - 1) begin
        upd_valid_i = 1'b0; exp_req_valid_i = 1'b0; out_valid_i = 1'b0;
      end
      tick();
    end
    #1;
    check("idle_busy", busy_o, 0);
    check("idle_we", mem_we_o, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rr_last = 2;
  endtask

  task automatic upd_tail(input logic [AW-1:0] a, input logic [SW-1:0] v);
    check("upd_we", mem_we_o, 1);
    check("upd_addr", mem_addr_o, a);
    check("upd_wdata", mem_wdata_o, v);
    ref_mem[a] = v;
    tick();
    check("upd_idle", busy_o, 0);
  endtask

  task automatic exp_tail(input logic [AW-1:0] a);
    check("exp_rd_we", mem_we_o, 0);
    check("exp_rd_addr", mem_addr_o, a);
    tick();
    check("exp_valid_early", exp_valid_o, 0);
    tick();
    check("exp_valid", exp_valid_o, 1);
    check("exp_seq", exp_seq_o, ref_mem[a]);
    check("exp_idle", busy_o, 0);
  endtask

  // delay > 0: done after delay cycles; 0: never (timeout); < 0: leave it waiting
  task automatic out_tail(input logic [AW-1:0] a, input int delay);
    logic [SW-1:0] old;
    logic [SW-1:0] nxt;
    int n;
    bit seen;
    old = ref_mem[a];
    nxt = old + 1;
    check("out_rd_we", mem_we_o, 0);
    check("out_rd_addr", mem_addr_o, a);
    tick();
    check("out_wr_we", mem_we_o, 1);
    check("out_wr_addr", mem_addr_o, a);
    check("out_wr_data", mem_wdata_o, nxt);
    ref_mem[a] = nxt;
    tick();
    check("conv_start", conv_start_o, 1);
    check("conv_bin", conv_bin_o, old);
    if (delay > 0) begin
      for (int i = 0; i < delay; i++) begin
        tick();
        if (i == 0) check("conv_start_pulse", conv_start_o, 0);
      end
      conv_done_i = 1'b1;
      tick();
      conv_done_i = 1'b0;
      check("out_valid", out_seq_valid_o, 1);
      check("out_bin", out_seq_bin_o, old);
      check("out_host", out_host_o, a);
    end else if (delay == 0) begin
      n = 0;
      seen = 1'b0;
      while (!err_timeout_o && n < CYC_LIMIT) begin
        tick();
        n++;
        if (out_seq_valid_o) seen = 1'b1;
      end
      check("timeout_latency", n, TO + 1);
      check("timeout_no_valid", seen, 0);
      check("timeout_idle", busy_o, 0);
    end else begin
      repeat (5) tick();
    end
  endtask

  // Holds all requested valids and services whichever requester the DUT grants.
  task automatic run_pending(input int n_upd, input bit want_e, input bit want_o,
                             input logic [AW-1:0] ua, input logic [SW-1:0] uv,
                             input logic [AW-1:0] ea, input logic [AW-1:0] oa,
                             input int delay);
    int pu;
    bit pe;
    bit po;
    int n;
    int g;
    logic [2:0] got;
    pu = n_upd; pe = want_e; po = want_o;
    upd_addr_i = ua; upd_value_i = uv; exp_addr_i = ea; out_addr_i = oa;
    while (pu > 0 || pe || po) begin
      upd_valid_i = (pu > 0); exp_req_valid_i = pe; out_valid_i = po;
      #1;
      n = 0;
      while (!(upd_ready_o || exp_req_ready_o || out_ready_o) && n < CYC_LIMIT) begin
        tick(); #1;
        n++;
      end
      if (n >= CYC_LIMIT) begin
        check("grant_wait", n, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "no grant");
      end
      g = exp_grant(pu, pe, po);
      got = {out_ready_o, exp_req_ready_o, upd_ready_o};
      check("grant", got, 3'b001 << g);
      tick();
      check("no_ready_busy", {out_ready_o, exp_req_ready_o, upd_ready_o}, 0);
      if (got[0]) begin
        last_acc[0] = cyc - 1; rr_last = 0;
        upd_valid_i = 1'b0;
        upd_tail(ua, uv);
        pu--;
        uv = $urandom;
        upd_value_i = uv;
      end else if (got[1]) begin
        last_acc[1] = cyc - 1; rr_last = 1;
        exp_req_valid_i = 1'b0;
        exp_tail(ea);
        pe = 1'b0;
      end else begin
        last_acc[2] = cyc - 1; rr_last = 2;
        out_valid_i = 1'b0;
        out_tail(oa, delay);
        po = 1'b0;
      end
    end
    upd_valid_i = 1'b0; exp_req_valid_i = 1'b0; out_valid_i = 1'b0;
  endtask

  initial begin
    int pu;
    bit pe;
    bit po;
    logic [SW-1:0] v;
    upd_addr_i = '0; upd_value_i = '0; exp_addr_i = '0; out_addr_i = '0;
    do_reset();

    // Update then lookup on host 3
    run_pending(1, 0, 0, 4'd3, 32'd100, 4'd0, 4'd0, 1);
    run_pending(0, 1, 0, 4'd0, 32'd0, 4'd3, 4'd0, 1);
    check("exp_accept_gap", last_acc[1] - last_acc[0], 2);

    // Allocation on host 3, then the counter reads back incremented
    run_pending(0, 0, 1, 4'd0, 32'd0, 4'd0, 4'd3, 10);
    run_pending(0, 1, 0, 4'd0, 32'd0, 4'd3, 4'd0, 1);

    // Wrap on host 5
    run_pending(1, 0, 0, 4'd5, 32'hFFFF_FFFF, 4'd0, 4'd0, 1);
    run_pending(0, 0, 1, 4'd0, 32'd0, 4'd0, 4'd5, 3);
    run_pending(0, 1, 0, 4'd0, 32'd0, 4'd5, 4'd0, 1);

    // Converter done outside WAIT_DONE has no effect
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    check("done_ignored_valid", out_seq_valid_o, 0);
    check("done_ignored_busy", busy_o, 0);

    // Three-way contention with a repeatedly valid updater
    run_pending(3, 1, 1, 4'd7, 32'd500, 4'd7, 4'd7, 4);

    for (int it = 0; it < 40; it++) begin
      pu = $urandom_range(0, 2);
      pe = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if (pu == 0 && !pe && !po) po = 1'b1;
      v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      run_pending(pu, pe, po, 4'($urandom_range(0, DEPTH - 1)), v,
                  4'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, DEPTH - 1)),
                  $urandom_range(1, 30));
    end

    // Converter never answers
    run_pending(0, 0, 1, 4'd0, 32'd0, 4'd0, 4'd2, 0);
    check("err_set", err_timeout_o, 1);
    run_pending(0, 1, 0, 4'd0, 32'd0, 4'd2, 4'd0, 1);
    check("err_sticky", err_timeout_o, 1);

    // Reset while waiting on the converter
    run_pending(0, 0, 1, 4'd0, 32'd0, 4'd0, 4'd4, -1);
    check("abort_busy", busy_o, 1);
    do_reset();
    run_pending(0, 1, 0, 4'd0, 32'd0, 4'd3, 4'd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
